// File: rtl/ddram_wr_fifo.sv
// Write-posting FIFO feeding the DDRAM arbiter's 16-bit write port over a toggle req/ack pair.
// Optional write coalescing into the newest queued entry: define WRFIFO_MERGE_EN.
//
// state  | meaning
// S_IDLE | no write outstanding; issue the head entry when count is non-zero
// S_WAIT | request toggled, holding wraddr/din until we_ack matches we_req

module ddram_wr_fifo #(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  DDRAM_CLK,
   input  logic                  reset,
   input  logic                  wr,
   input  logic [30:0]           wr_addr,
   input  logic [15:0]           wr_data,
   output logic                  full,
   output logic                  empty,
   output logic                  overflow,
   output logic [DEPTH_LOG2:0]   count,
   output logic [30:0]           wraddr,
   output logic [15:0]           din,
   output logic                  we_req,
   input  logic                  we_ack
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   CNT_ONE   = 1;
   localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = DEPTH;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t                  state;
   logic [DEPTH_LOG2-1:0]   head;
   logic [DEPTH_LOG2-1:0]   tail;
   logic [30:0]             mem_addr [DEPTH];
   logic [15:0]             mem_data [DEPTH];
   logic                    push;
   logic                    pop;
   logic                    merge;
   logic [DEPTH_LOG2-1:0]   wr_idx;
   logic [DEPTH_LOG2:0]     count_nxt;

`ifdef WRFIFO_MERGE_EN
   localparam logic [DEPTH_LOG2:0] CNT_TWO = 2;
   logic [DEPTH_LOG2-1:0]   tail_prev;

   // count >= 2 keeps the merge target away from the in-flight head entry
   assign tail_prev = tail - PTR_ONE;
   assign merge     = wr && (count >= CNT_TWO) && (mem_addr[tail_prev] == wr_addr);
   assign wr_idx    = merge ? tail_prev : tail;
`else
   assign merge     = 1'b0;
   assign wr_idx    = tail;
`endif

   assign push = wr && !full && !merge;
   assign pop  = (state == S_WAIT) && (we_ack == we_req);

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + CNT_ONE;
      else if (!push && pop)
         count_nxt = count - CNT_ONE;
   end

   always_ff @(posedge DDRAM_CLK) begin
      if (!reset && (push || merge)) begin
         mem_addr[wr_idx] <= wr_addr;
         mem_data[wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge DDRAM_CLK) begin
      if (reset) begin
         state    <= S_IDLE;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
         wraddr   <= '0;
         din      <= '0;
         // follow the ack so a write cut off by reset never looks like a fresh request
         we_req   <= we_ack;
      end else begin
         if (push)
            tail <= tail + PTR_ONE;
         if (pop)
            head <= head + PTR_ONE;
         if (wr && full && !merge)
            overflow <= 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == CNT_DEPTH);
         empty <= (count_nxt == '0);

         case (state)
            S_IDLE: begin
               if (count != '0) begin
                  wraddr <= mem_addr[head];
                  din    <= mem_data[head];
                  we_req <= ~we_req;
                  state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (pop)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
